game_ctrl: RTL and testbench

Game-flow controller between the keyboard driver, the VGA sync generator and the renderer. It synchronises `vsync` into the system clock domain and issues one frame strobe per displayed frame. It latches keyboard edges and renderer events between frames, and runs the TITLE/PLAY/DEAD/CLEAR state machine. From that state machine it gates the renderer's physics step and issues the world-reset pulses.

---
 rtl/game_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_game_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_ctrl.sv
// Game-flow controller: vsync frame strobe, per-frame key/event sampling and TITLE/PLAY/DEAD/CLEAR FSM.
// Define GAME_CTRL_DEATH_CNT_EN to build the saturating death counter; otherwise death_count is 0.
module game_ctrl #(
  parameter int unsigned CLEAR_FRAMES     = 120,
  parameter bit          VSYNC_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       vsync,
  input  logic [5:0] keys,
  input  logic       dead,
  input  logic       goal,
  output logic       frame_tick,
  output logic       step,
  output logic       world_rst,
  output logic [4:0] keys_frame,
  output logic       jump_press,
  output logic       jump_release,
  output logic [1:0] state,
  output logic [7:0] death_count
);

  localparam logic [1:0] ST_TITLE = 2'd0;
  localparam logic [1:0] ST_PLAY  = 2'd1;
  localparam logic [1:0] ST_DEAD  = 2'd2;
  localparam logic [1:0] ST_CLEAR = 2'd3;
  localparam logic [7:0] CLEAR_LIM = 8'(CLEAR_FRAMES);

  logic       vs_meta_q, vs_meta_d;
  logic       vs_sync_q, vs_sync_d;
  logic       vs_prev_q, vs_prev_d;
  logic       tick_q, tick_d;
  logic       jump_prev_q, jump_prev_d;
  logic       start_prev_q, start_prev_d;
  logic       restart_prev_q, restart_prev_d;
  logic       lat_jr_q, lat_jr_d;
  logic       lat_jf_q, lat_jf_d;
  logic       lat_st_q, lat_st_d;
  logic       lat_rs_q, lat_rs_d;
  logic       lat_dead_q, lat_dead_d;
  logic       lat_goal_q, lat_goal_d;
  logic [1:0] state_q, state_d;
  logic [7:0] clr_cnt_q, clr_cnt_d;
  logic       step_q, step_d;
  logic       world_rst_q, world_rst_d;
  logic [4:0] keys_frame_q, keys_frame_d;
  logic       jump_press_q, jump_press_d;
  logic       jump_release_q, jump_release_d;
  logic       jr_evt, jf_evt, st_evt, rs_evt;
  logic       s_jr, s_jf, s_st, s_rs, s_dead, s_goal;
`ifdef GAME_CTRL_DEATH_CNT_EN
  logic [7:0] death_q, death_d;
`endif

  always_comb begin
    vs_meta_d      = vsync;
    vs_sync_d      = vs_meta_q;
    vs_prev_d      = vs_sync_q;
    tick_d         = VSYNC_ACTIVE_LOW ? (vs_prev_q & ~vs_sync_q) : (~vs_prev_q & vs_sync_q);
    jump_prev_d    = keys[2];
    start_prev_d   = keys[4];
    restart_prev_d = keys[5];

    jr_evt = keys[2] & ~jump_prev_q;
    jf_evt = ~keys[2] & jump_prev_q;
    st_evt = keys[4] & ~start_prev_q;
    rs_evt = keys[5] & ~restart_prev_q;

    // Same-cycle events are folded into the sample so a tick-cycle edge is counted exactly once.
    s_jr   = lat_jr_q | jr_evt;
    s_jf   = lat_jf_q | jf_evt;
    s_st   = lat_st_q | st_evt;
    s_rs   = lat_rs_q | rs_evt;
    s_dead = lat_dead_q | dead;
    s_goal = lat_goal_q | goal;

    lat_jr_d   = tick_q ? 1'b0 : s_jr;
    lat_jf_d   = tick_q ? 1'b0 : s_jf;
    lat_st_d   = tick_q ? 1'b0 : s_st;
    lat_rs_d   = tick_q ? 1'b0 : s_rs;
    lat_dead_d = tick_q ? 1'b0 : s_dead;
    lat_goal_d = tick_q ? 1'b0 : s_goal;

    state_d        = state_q;
    clr_cnt_d      = clr_cnt_q;
    step_d         = 1'b0;
    world_rst_d    = 1'b0;
    keys_frame_d   = keys_frame_q;
    jump_press_d   = jump_press_q;
    jump_release_d = jump_release_q;
`ifdef GAME_CTRL_DEATH_CNT_EN
    death_d        = death_q;
`endif

    if (tick_q) begin
      keys_frame_d   = keys[4:0];
      jump_press_d   = s_jr;
      jump_release_d = s_jf;
      case (state_q)
        ST_TITLE: begin
          if (s_st || s_jr) begin
            state_d     = ST_PLAY;
            world_rst_d = 1'b1;
          end
        end
        ST_PLAY: begin
          if (s_dead) begin
            state_d = ST_DEAD;
`ifdef GAME_CTRL_DEATH_CNT_EN
            if (death_q != 8'hFF) death_d = death_q + 8'd1;
`endif
          end else if (s_goal) begin
            state_d   = ST_CLEAR;
            clr_cnt_d = 8'd0;
          end else if (s_rs) begin
            world_rst_d = 1'b1;
          end else begin
            step_d = 1'b1;
          end
        end
        ST_DEAD: begin
          if (s_rs || s_jr) begin
            state_d     = ST_PLAY;
            world_rst_d = 1'b1;
          end
        end
        default: begin
          if (clr_cnt_q == CLEAR_LIM) begin
            state_d     = ST_TITLE;
            world_rst_d = 1'b1;
          end else begin
            clr_cnt_d = clr_cnt_q + 8'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      vs_meta_q      <= 1'b0;
      vs_sync_q      <= 1'b0;
      vs_prev_q      <= 1'b0;
      tick_q         <= 1'b0;
      jump_prev_q    <= 1'b0;
      start_prev_q   <= 1'b0;
      restart_prev_q <= 1'b0;
      lat_jr_q       <= 1'b0;
      lat_jf_q       <= 1'b0;
      lat_st_q       <= 1'b0;
      lat_rs_q       <= 1'b0;
      lat_dead_q     <= 1'b0;
      lat_goal_q     <= 1'b0;
      state_q        <= ST_TITLE;
      clr_cnt_q      <= 8'd0;
      step_q         <= 1'b0;
      world_rst_q    <= 1'b0;
      keys_frame_q   <= 5'd0;
      jump_press_q   <= 1'b0;
      jump_release_q <= 1'b0;
`ifdef GAME_CTRL_DEATH_CNT_EN
      death_q        <= 8'd0;
`endif
    end else begin
      vs_meta_q      <= vs_meta_d;
      vs_sync_q      <= vs_sync_d;
      vs_prev_q      <= vs_prev_d;
      tick_q         <= tick_d;
      jump_prev_q    <= jump_prev_d;
      start_prev_q   <= start_prev_d;
      restart_prev_q <= restart_prev_d;
      lat_jr_q       <= lat_jr_d;
      lat_jf_q       <= lat_jf_d;
      lat_st_q       <= lat_st_d;
      lat_rs_q       <= lat_rs_d;
      lat_dead_q     <= lat_dead_d;
      lat_goal_q     <= lat_goal_d;
      state_q        <= state_d;
      clr_cnt_q      <= clr_cnt_d;
      step_q         <= step_d;
      world_rst_q    <= world_rst_d;
      keys_frame_q   <= keys_frame_d;
      jump_press_q   <= jump_press_d;
      jump_release_q <= jump_release_d;
`ifdef GAME_CTRL_DEATH_CNT_EN
      death_q        <= death_d;
`endif
    end
  end

  assign frame_tick   = tick_q;
  assign step         = step_q;
  assign world_rst    = world_rst_q;
  assign keys_frame   = keys_frame_q;
  assign jump_press   = jump_press_q;
  assign jump_release = jump_release_q;
  assign state        = state_q;
`ifdef GAME_CTRL_DEATH_CNT_EN
  assign death_count  = death_q;
`else
  assign death_count  = 8'd0;
`endif

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: directed scenarios plus random play, checked every cycle against a frame-level model.
module tb_game_ctrl;
  localparam int CF = 3;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       vsync = 1'b1;
  logic [5:0] keys = 6'd0;
  logic       dead = 1'b0;
  logic       goal = 1'b0;
  logic       frame_tick, step, world_rst, jump_press, jump_release;
  logic [4:0] keys_frame;
  logic [1:0] state;
  logic [7:0] death_count;

  game_ctrl #(.CLEAR_FRAMES(CF), .VSYNC_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .clrn(clrn), .vsync(vsync), .keys(keys), .dead(dead), .goal(goal),
    .frame_tick(frame_tick), .step(step), .world_rst(world_rst), .keys_frame(keys_frame),
    .jump_press(jump_press), .jump_release(jump_release), .state(state), .death_count(death_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

`ifdef GAME_CTRL_DEATH_CNT_EN
  localparam bit DC_EN = 1'b1;
`else
  localparam bit DC_EN = 1'b0;
`endif

  // Frame-level reference: ticks are scheduled from vsync falls, decisions made once per frame.
  int       cyc = 0;
  int       tickq[$];
  int       n_frames = 0;
  bit       m_vs_last, m_tick, m_tick_prev;
  bit [5:0] m_kprev;
  bit       f_jr, f_jf, f_st, f_rs, f_dead, f_goal;
  int       m_state, m_cnt, m_dc;
  bit       m_step, m_wr, m_jp, m_jrel;
  bit [4:0] m_kf;

  task automatic model_reset();
    tickq.delete();
    m_vs_last = 0; m_tick = 0; m_tick_prev = 0; m_kprev = '0;
    f_jr = 0; f_jf = 0; f_st = 0; f_rs = 0; f_dead = 0; f_goal = 0;
    m_state = 0; m_cnt = 0; m_dc = 0;
    m_step = 0; m_wr = 0; m_jp = 0; m_jrel = 0; m_kf = '0;
  endtask

  always @(posedge clk) begin
    bit       vs_i, d_i, g_i;
    bit [5:0] k_i;
    bit       jr, jf, st, rs;
    cyc++;
    if (!clrn) begin
      model_reset();
    end else begin
      vs_i = vsync; k_i = keys; d_i = dead; g_i = goal;
      m_tick_prev = m_tick;
      if (m_vs_last && !vs_i) tickq.push_back(cyc + 2);
      m_vs_last = vs_i;
      m_tick = (tickq.size() > 0 && tickq[0] == cyc);
      if (m_tick) void'(tickq.pop_front());
      jr = k_i[2] & ~m_kprev[2];
      jf = ~k_i[2] & m_kprev[2];
      st = k_i[4] & ~m_kprev[4];
      rs = k_i[5] & ~m_kprev[5];
      m_kprev = k_i;
      m_step = 0; m_wr = 0;
      if (m_tick_prev) begin
        bit s_jr, s_jf, s_st, s_rs, s_dead, s_goal;
        s_jr = f_jr | jr; s_jf = f_jf | jf; s_st = f_st | st;
        s_rs = f_rs | rs; s_dead = f_dead | d_i; s_goal = f_goal | g_i;
        f_jr = 0; f_jf = 0; f_st = 0; f_rs = 0; f_dead = 0; f_goal = 0;
        m_kf = k_i[4:0]; m_jp = s_jr; m_jrel = s_jf;
        case (m_state)
          0: if (s_st || s_jr) begin m_state = 1; m_wr = 1; end
          1: begin
            if (s_dead) begin
              m_state = 2;
              if (DC_EN && m_dc < 255) m_dc++;
            end else if (s_goal) begin
              m_state = 3; m_cnt = 0;
            end else if (s_rs) m_wr = 1;
            else m_step = 1;
          end
          2: if (s_rs || s_jr) begin m_state = 1; m_wr = 1; end
          default: begin
            if (m_cnt == CF) begin m_state = 0; m_wr = 1; end
            else m_cnt++;
          end
        endcase
        n_frames++;
        $display("frame %0d: state=%0d step=%0d world_rst=%0d keys_frame=%b jp=%0d jr=%0d deaths=%0d",
                 n_frames, m_state, m_step, m_wr, m_kf, m_jp, m_jrel, m_dc);
      end else begin
        f_jr |= jr; f_jf |= jf; f_st |= st; f_rs |= rs; f_dead |= d_i; f_goal |= g_i;
      end
    end
    #1;
    check("cyc_frame_tick", int'(frame_tick), int'(m_tick));
    check("cyc_step", int'(step), int'(m_step));
    check("cyc_world_rst", int'(world_rst), int'(m_wr));
    check("cyc_state", int'(state), m_state);
    check("cyc_keys_frame", int'(keys_frame), int'(m_kf));
    check("cyc_jump_press", int'(jump_press), int'(m_jp));
    check("cyc_jump_release", int'(jump_release), int'(m_jrel));
    check("cyc_death_count", int'(death_count), m_dc);
  end

  task automatic cyc_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the tick's update edge (T+1).
  task automatic frame();
    vsync = 1'b0;
    cyc_n(2);
    check("tick_not_early", int'(frame_tick), 0);
    cyc_n(1);
    check("tick_after_3", int'(frame_tick), 1);
    cyc_n(1);
    vsync = 1'b1;
  endtask

  task automatic pulse_key(input int b, input int len);
    keys[b] = 1'b1;
    cyc_n(len);
    keys[b] = 1'b0;
    cyc_n(2);
  endtask

  task automatic pulse_event(input bit d, input bit g);
    dead = d; goal = g;
    cyc_n(1);
    dead = 1'b0; goal = 1'b0;
    cyc_n(2);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, b;
    cyc_n(3);
    check("rst_state", int'(state), 0);
    check("rst_step", int'(step), 0);
    check("rst_world_rst", int'(world_rst), 0);
    check("rst_tick", int'(frame_tick), 0);
    clrn = 1'b1;
    cyc_n(4);

    frame();
    check("first_state", int'(state), 0);
    check("first_step", int'(step), 0);
    check("first_world_rst", int'(world_rst), 0);
    cyc_n(5);

    pulse_key(4, 2);
    frame();
    check("start_state", int'(state), 1);
    check("start_world_rst", int'(world_rst), 1);
    cyc_n(1);
    check("start_wr_one_cycle", int'(world_rst), 0);
    cyc_n(5);
    frame();
    check("play_step", int'(step), 1);
    cyc_n(4);

    pulse_event(1'b1, 1'b1);
    frame();
    check("death_state", int'(state), 2);
    check("death_count_1", int'(death_count), DC_EN ? 1 : 0);
    check("death_no_step", int'(step), 0);
    cyc_n(4);
    pulse_key(5, 2);
    frame();
    check("restart_state", int'(state), 1);
    check("restart_world_rst", int'(world_rst), 1);
    cyc_n(4);

    // jump rises one cycle before the tick, falls ten cycles after it
    vsync = 1'b0;
    cyc_n(2);
    keys[2] = 1'b1;
    cyc_n(1);
    check("jump_tick", int'(frame_tick), 1);
    cyc_n(1);
    vsync = 1'b1;
    check("jump_press_f1", int'(jump_press), 1);
    check("jump_release_f1", int'(jump_release), 0);
    check("keys_frame2_f1", int'(keys_frame[2]), 1);
    cyc_n(9);
    keys[2] = 1'b0;
    cyc_n(5);
    frame();
    check("jump_press_f2", int'(jump_press), 0);
    check("jump_release_f2", int'(jump_release), 1);
    check("keys_frame2_f2", int'(keys_frame[2]), 0);
    cyc_n(4);

    pulse_event(1'b0, 1'b1);
    frame();
    check("clear_enter", int'(state), 3);
    for (int i = 0; i < CF; i++) begin
      cyc_n(4);
      frame();
      check("clear_hold", int'(state), 3);
      check("clear_no_wr", int'(world_rst), 0);
    end
    cyc_n(4);
    frame();
    check("clear_exit_state", int'(state), 0);
    check("clear_exit_wr", int'(world_rst), 1);
    cyc_n(4);

    pulse_key(4, 1);
    frame();
    cyc_n(3);
    pulse_event(1'b0, 1'b1);
    frame();
    check("clear2_enter", int'(state), 3);
    cyc_n(3);
    frame();
    cyc_n(3);
    #2 clrn = 1'b0;
    #1;
    check("async_rst_state", int'(state), 0);
    check("async_rst_deaths", int'(death_count), 0);
    check("async_rst_jp", int'(jump_press), 0);
    cyc_n(3);
    clrn = 1'b1;
    cyc_n(4);

    pulse_key(4, 1);
    frame();
    check("sat_start", int'(state), 1);
    cyc_n(3);
    for (int i = 0; i < 260; i++) begin
      pulse_event(1'b1, 1'b0);
      frame();
      cyc_n(2);
      pulse_key(5, 1);
      frame();
      cyc_n(2);
    end
    check("sat_death_count", int'(death_count), DC_EN ? 255 : 0);
    check("sat_state", int'(state), 1);

    for (int f = 0; f < 200; f++) begin
      len = $urandom_range(8, 30);
      for (int c = 0; c < len; c++) begin
        vsync = (c < 3) ? 1'b0 : 1'b1;
        if ($urandom_range(0, 5) == 0) begin
          b = $urandom_range(0, 5);
          keys[b] = ~keys[b];
        end
        dead = ($urandom_range(0, 19) == 0);
        goal = ($urandom_range(0, 29) == 0);
        if (f % 60 == 30 && c == 5) begin
          #2 clrn = 1'b0;
          #1;
          check("rand_async_rst_state", int'(state), 0);
          @(negedge clk);
          @(negedge clk);
          clrn = 1'b1;
        end else begin
          @(negedge clk);
        end
      end
    end
    keys = 6'd0; dead = 1'b0; goal = 1'b0; vsync = 1'b1;
    cyc_n(10);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
